iomem_rr_arbiter: RTL and testbench
===================================

Name: iomem_rr_arbiter

Overview:
- Two-requester round-robin arbiter that shares the single iomem memory port (valid/ready/wstrb/addr/wdata/rdata) between the processor core (m0) and a secondary master (m1, loader/DMA).
- Sits between the requesters and the external RAM model/controller, which may insert any number of wait cycles before ready.
- Grants one transaction at a time and forwards the granted master's command.
- Returns the response only to the granted master.

Parameters:
ADDR_WIDTH, 32, width of address buses
DATA_WIDTH, 32, width of data buses (wstrb width = DATA_WIDTH/8)
TIMEOUT_CYCLES, 256, BUSY cycles without s_ready before watchdog abort (used only with IOMEM_ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock
resetn  in  1  synchronous reset, active-low
m0_valid  in  1  master 0 request
m0_ready  out  1  master 0 transaction complete (1-cycle pulse)
m0_wstrb  in  DATA_WIDTH/8  master 0 byte write strobes, 0 = read
m0_addr  in  ADDR_WIDTH  master 0 address
m0_wdata  in  DATA_WIDTH  master 0 write data
m0_rdata  out  DATA_WIDTH  master 0 read data, valid when m0_ready
m1_valid/m1_ready/m1_wstrb/m1_addr/m1_wdata/m1_rdata  same as master 0, for master 1
s_valid  out  1  request to memory
s_ready  in  1  memory completion
s_wstrb  out  DATA_WIDTH/8  forwarded strobes
s_addr  out  ADDR_WIDTH  forwarded address
s_wdata  out  DATA_WIDTH  forwarded write data
s_rdata  in  DATA_WIDTH  memory read data
grant_o  out  1  current/last grant index (0 = m0, 1 = m1)
err_o  out  1  sticky watchdog error flag
err_clr_i  in  1  clears err_o

Behaviour:
- Reset (clk rising edge, resetn = 0), all values visible after that edge:
  - state = IDLE, s_valid = 0, m0_ready = m1_ready = 0, grant_o = 0.
  - last-served pointer = 1, so m0 wins the first tie.
  - err_o = 0.
  - Reset mid-transaction abandons it: no ready pulse to any master; s_valid is 0 after the reset edge.
- Master protocol:
  - A master holds valid, addr, wstrb and wdata stable until it sees ready.
  - After ready, it may drop valid or present a new request on the next cycle.
- States:
  - IDLE: s_valid = 0.
    - If exactly one master's valid = 1, grant it.
    - If both are valid, grant the master that is not the last served (round-robin).
    - On a grant, latch the grant index and go to BUSY at the next edge.
    - With no valid input, stay in IDLE.
  - BUSY: s_valid = 1.
    - s_addr, s_wstrb and s_wdata are a combinational mux of the granted master's inputs.
    - The granted master's ready = s_ready (combinational); its rdata = s_rdata.
    - When s_ready = 1: update last-served to the grant and return to IDLE at the next edge.
    - s_valid stays 1 until s_ready, even if the granted master drops valid (protocol violation; the transaction still completes).
- Timing:
  - Request accepted at cycle t → s_valid = 1 from cycle t+1.
  - Minimum transaction length is 2 cycles. There is one mandatory IDLE bubble between back-to-back transactions.
- Non-granted master: ready = 0; rdata = 0.
- In IDLE, s_addr, s_wstrb and s_wdata show the m0 inputs. Memory must ignore them because s_valid = 0.
- grant_o: updates when BUSY is entered and holds its value through IDLE.
- Starvation bound: a continuously valid master is served within at most one other transaction.
- Cycles where s_ready is asserted while in IDLE are ignored.

Optional Feature:
- Macro: IOMEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on BUSY entry and increments each BUSY cycle with s_ready = 0.
  - When it reaches TIMEOUT_CYCLES-1 with s_ready still 0, the arbiter:
    - drives the granted master's ready = 1 for that cycle, with rdata = 32'hDEAD_BEEF (truncated/zero-extended to DATA_WIDTH);
    - sets err_o at the next edge;
    - returns to IDLE, updating last-served to the aborted master.
  - err_o stays set until err_clr_i = 1 at an edge. If a new timeout occurs in the same cycle as err_clr_i, set wins.
- Undefined: no counter; BUSY waits indefinitely; err_o is tied to 0; err_clr_i is ignored.

Test Plan:
- Single read on m0: addr 0x4000_0010, wstrb 0, memory ready 1 cycle after s_valid with rdata 0x1234_5678 → s_valid is high at t+1 and t+2; m0_ready pulses at t+2 with m0_rdata = 0x1234_5678; m1_ready stays 0.
- Simultaneous requests after reset: m0 write 0x4000_0000 ← 0xAAAA_AAAA (wstrb 0xF), m1 read 0x4000_0004 → m0 is served first (grant_o = 0), then m1 after one IDLE bubble (grant_o = 1); memory sees exactly 2 transactions in that order.
- Both masters valid continuously for 8 transactions → grants alternate 0,1,0,1,…; each master completes exactly 4.
- Memory delay of 5 cycles, m1 write with wstrb 0x3 → s_wstrb = 0x3 and s_addr/s_wdata equal the m1 inputs stable for all 6 BUSY cycles; m1_ready is a single pulse.
- resetn asserted during BUSY (after 2 wait cycles) → s_valid = 0 after the reset edge; no ready pulse; next request from m1 alone is granted normally.
- IOMEM_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES = 16, s_ready never asserted → granted master's ready pulses in BUSY cycle 16 with rdata 0xDEAD_BEEF; err_o = 1 next cycle; err_clr_i pulse → err_o = 0.

Source files
------------

// File: rtl/iomem_rr_arbiter.sv
// iomem_rr_arbiter
// ----------------
// Purpose: shares one iomem memory port between two masters (m0 = core,
// m1 = loader/DMA). One transaction is in flight at a time. When both
// masters request together, the one that was not served last wins.
// The command of the granted master is forwarded to the memory, and the
// response is returned only to that master.
//
// Ports:
//   clk, resetn            clock; synchronous active-low reset
//   m0_* / m1_*            master ports: valid, wstrb, addr and wdata in;
//                          ready (1-cycle pulse) and rdata out
//   s_*                    memory port: valid, wstrb, addr and wdata out;
//                          ready and rdata in
//   grant_o                current or last grant (0 = m0, 1 = m1)
//   err_o, err_clr_i       sticky watchdog error flag and its clear
//
// Optional feature: define IOMEM_ARB_TIMEOUT_EN to enable a watchdog. It
// aborts a BUSY transaction after TIMEOUT_CYCLES cycles without s_ready.
// An aborted transaction returns 32'hDEAD_BEEF and sets err_o. Without the
// macro, err_o is tied low and err_clr_i is ignored.

module iomem_rr_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    m0_valid,
  output logic                    m0_ready,
  input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  input  logic                    m1_valid,
  output logic                    m1_ready,
  input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic                    s_valid,
  input  logic                    s_ready,
  output logic [DATA_WIDTH/8-1:0] s_wstrb,
  output logic [ADDR_WIDTH-1:0]   s_addr,
  output logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH-1:0]   s_rdata,
  output logic                    grant_o,
  output logic                    err_o,
  input  logic                    err_clr_i
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t r_state;
  logic   r_grant;   // master currently (or most recently) granted
  logic   r_last;    // master served last; a tie goes to the other one

  logic                  w_busy;
  logic                  w_pick;
  logic                  w_abort;
  logic                  w_done;
  logic                  w_sel1;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_busy = (r_state == ST_BUSY);

  // A lone requester wins. On a tie, the master not served last wins.
  assign w_pick = (m0_valid && m1_valid) ? ~r_last : m1_valid;

`ifdef IOMEM_ARB_TIMEOUT_EN
  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_err;

  // BUSY cycle n without s_ready has a count of n-1, so the abort happens in
  // BUSY cycle TIMEOUT_CYCLES.
  assign w_abort = w_busy && !s_ready &&
                   (r_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      // Holding the count at zero outside BUSY gives a zero count on BUSY entry.
      if (!w_busy) begin
        r_cnt <= '0;
      end else if (!s_ready) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // A new abort takes priority over a clear in the same cycle.
      if (w_abort) begin
        r_err <= 1'b1;
      end else if (err_clr_i) begin
        r_err <= 1'b0;
      end
    end
  end

  assign err_o   = r_err;
  assign w_rdata = w_abort ? DATA_WIDTH'(32'hDEAD_BEEF) : s_rdata;
`else
  logic w_unused;
  assign w_unused = err_clr_i;
  assign w_abort  = 1'b0;
  assign err_o    = 1'b0;
  assign w_rdata  = s_rdata;
`endif

  assign w_done = w_busy && (s_ready || w_abort);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_grant <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (m0_valid || m1_valid) begin
            r_grant <= w_pick;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // The transaction stays open until completion, even if the
          // granted master drops valid too early.
          if (w_done) begin
            r_last  <= r_grant;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // In IDLE the memory port shows the m0 inputs. s_valid is low, so the
  // memory ignores them.
  assign w_sel1  = w_busy && r_grant;
  assign s_valid = w_busy;
  assign s_addr  = w_sel1 ? m1_addr  : m0_addr;
  assign s_wstrb = w_sel1 ? m1_wstrb : m0_wstrb;
  assign s_wdata = w_sel1 ? m1_wdata : m0_wdata;

  assign m0_ready = w_done && !r_grant;
  assign m1_ready = w_done && r_grant;
  assign m0_rdata = (w_busy && !r_grant) ? w_rdata : '0;
  assign m1_rdata = (w_busy && r_grant)  ? w_rdata : '0;
  assign grant_o  = r_grant;

endmodule

// File: tb/tb_iomem_rr_arbiter.sv
// tb_iomem_rr_arbiter
// -------------------
// Directed bench for iomem_rr_arbiter. Inputs change on the falling clock
// edge. Outputs are sampled 1 ns later. The rising edge is the active edge.

module tb_iomem_rr_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic          m0_valid, m0_ready, m1_valid, m1_ready;
  logic [3:0]    m0_wstrb, m1_wstrb, s_wstrb;
  logic [AW-1:0] m0_addr, m1_addr, s_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, s_wdata, s_rdata;
  logic          s_valid, s_ready, grant_o, err_o, err_clr_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iomem_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_wstrb(m0_wstrb),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_wstrb(m1_wstrb),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_wstrb(s_wstrb),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
    .grant_o(grant_o), .err_o(err_o), .err_clr_i(err_clr_i)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    m0_valid = 0; m0_wstrb = 0; m0_addr = 0; m0_wdata = 0;
    m1_valid = 0; m1_wstrb = 0; m1_addr = 0; m1_wdata = 0;
    s_ready = 0; s_rdata = 0; err_clr_i = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    resetn = 0;
    cyc(); cyc(); #1;
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_s_valid got %b want 0", s_valid); end
    checks++; if ({m0_ready, m1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", {m0_ready, m1_ready}); end
    checks++; if (grant_o !== 1'b0) begin errors++; $display("FAIL reset_grant got %b want 0", grant_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_o); end
    resetn = 1;
  endtask

  task automatic test_single_read();
    cyc();
    m0_valid = 1; m0_addr = 32'h4000_0010; m0_wstrb = 4'h0; #1;
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rd_t0_s_valid got %b want 0", s_valid); end
    cyc(); #1;
    checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL rd_t1_s_valid got %b want 1", s_valid); end
    checks++; if (s_addr !== 32'h4000_0010 || s_wstrb !== 4'h0) begin errors++; $display("FAIL rd_t1_cmd got %h/%h want 40000010/0", s_addr, s_wstrb); end
    checks++; if (m0_ready !== 1'b0) begin errors++; $display("FAIL rd_t1_ready got %b want 0", m0_ready); end
    cyc();
    s_ready = 1; s_rdata = 32'h1234_5678; #1;
    checks++; if (s_valid !== 1'b1 || m0_ready !== 1'b1) begin errors++; $display("FAIL rd_t2_done got valid=%b ready=%b want 1/1", s_valid, m0_ready); end
    checks++; if (m0_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_t2_rdata got %h want 12345678", m0_rdata); end
    checks++; if (m1_ready !== 1'b0 || m1_rdata !== 32'h0) begin errors++; $display("FAIL rd_t2_m1 got ready=%b rdata=%h want 0/0", m1_ready, m1_rdata); end
    $display("txn single_read grant=%0d addr=%h rdata=%h", grant_o, s_addr, m0_rdata);
    cyc();
    m0_valid = 0; s_ready = 0; #1;
    checks++; if (s_valid !== 1'b0 || m0_ready !== 1'b0) begin errors++; $display("FAIL rd_t3_idle got valid=%b ready=%b want 0/0", s_valid, m0_ready); end
  endtask

  task automatic test_simultaneous();
    logic          cap_g [4];
    logic [AW-1:0] cap_a [4];
    logic [3:0]    cap_w [4];
    logic [DW-1:0] cap_d [4];
    int            cap_c [4];
    int            ncap;
    logic          drop0, drop1;
    resetn = 0; cyc(); cyc(); resetn = 1;
    cyc();
    m0_valid = 1; m0_addr = 32'h4000_0000; m0_wstrb = 4'hF; m0_wdata = 32'hAAAA_AAAA;
    m1_valid = 1; m1_addr = 32'h4000_0004; m1_wstrb = 4'h0; m1_wdata = 32'h0;
    ncap = 0; drop0 = 0; drop1 = 0;
    for (int c = 0; c < 12; c++) begin
      cyc();
      if (drop0) m0_valid = 0;
      if (drop1) m1_valid = 0;
      s_ready = s_valid; s_rdata = 32'h0BAD_0000 + c; #1;
      if (s_ready) begin
        if (ncap < 4) begin
          cap_g[ncap] = grant_o; cap_a[ncap] = s_addr; cap_w[ncap] = s_wstrb;
          cap_d[ncap] = s_wdata; cap_c[ncap] = c;
        end
        $display("txn simultaneous grant=%0d addr=%h wstrb=%h", grant_o, s_addr, s_wstrb);
        ncap++;
      end
      if (m0_ready) drop0 = 1;
      if (m1_ready) drop1 = 1;
    end
    s_ready = 0;
    checks++; if (ncap !== 2) begin errors++; $display("FAIL sim_count got %0d want 2", ncap); end
    if (ncap >= 2) begin
      checks++; if (cap_g[0] !== 1'b0 || cap_a[0] !== 32'h4000_0000 || cap_w[0] !== 4'hF || cap_d[0] !== 32'hAAAA_AAAA) begin
        errors++; $display("FAIL sim_first got g=%b a=%h w=%h d=%h want 0/40000000/f/aaaaaaaa", cap_g[0], cap_a[0], cap_w[0], cap_d[0]);
      end
      checks++; if (cap_g[1] !== 1'b1 || cap_a[1] !== 32'h4000_0004 || cap_w[1] !== 4'h0) begin
        errors++; $display("FAIL sim_second got g=%b a=%h w=%h want 1/40000004/0", cap_g[1], cap_a[1], cap_w[1]);
      end
      checks++; if (cap_c[1] - cap_c[0] !== 2) begin errors++; $display("FAIL sim_bubble got spacing %0d want 2", cap_c[1] - cap_c[0]); end
    end
  endtask

  task automatic test_back_to_back();
    logic cap_g [8];
    int   ncap, n0, n1;
    cyc();
    m0_valid = 1; m0_addr = 32'h0000_0100; m0_wstrb = 4'h0;
    m1_valid = 1; m1_addr = 32'h0000_0200; m1_wstrb = 4'h0;
    ncap = 0; n0 = 0; n1 = 0;
    for (int c = 0; c < 40 && ncap < 8; c++) begin
      cyc();
      s_ready = s_valid; s_rdata = 32'h5555_0000 + c; #1;
      if (s_ready) begin
        cap_g[ncap] = grant_o;
        $display("txn back_to_back n=%0d grant=%0d addr=%h", ncap, grant_o, s_addr);
        ncap++;
      end
      if (m0_ready) n0++;
      if (m1_ready) n1++;
    end
    cyc();
    s_ready = 0; m0_valid = 0; m1_valid = 0;
    checks++; if (ncap !== 8) begin errors++; $display("FAIL b2b_count got %0d want 8", ncap); end
    for (int k = 0; k < ncap; k++) begin
      checks++; if (cap_g[k] !== 1'(k % 2)) begin errors++; $display("FAIL b2b_grant_%0d got %b want %0d", k, cap_g[k], k % 2); end
    end
    checks++; if (n0 !== 4 || n1 !== 4) begin errors++; $display("FAIL b2b_per_master got %0d/%0d want 4/4", n0, n1); end
  endtask

  task automatic test_wait_write();
    int pulses;
    cyc();
    m1_valid = 1; m1_addr = 32'h4000_0100; m1_wstrb = 4'h3; m1_wdata = 32'h55AA_1234;
    m0_addr = 32'hFFFF_0000; m0_wstrb = 4'hC; m0_wdata = 32'h0F0F_0F0F;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      s_ready = (i == 5); s_rdata = 32'h0; #1;
      checks++; if (s_valid !== 1'b1 || grant_o !== 1'b1) begin errors++; $display("FAIL ww_busy_%0d got valid=%b grant=%b want 1/1", i, s_valid, grant_o); end
      checks++; if (s_addr !== 32'h4000_0100 || s_wstrb !== 4'h3 || s_wdata !== 32'h55AA_1234) begin
        errors++; $display("FAIL ww_cmd_%0d got %h/%h/%h want 40000100/3/55aa1234", i, s_addr, s_wstrb, s_wdata);
      end
      if (m1_ready) pulses++;
      checks++; if (m0_ready !== 1'b0) begin errors++; $display("FAIL ww_m0_ready_%0d got 1 want 0", i); end
    end
    $display("txn wait_write grant=%0d addr=%h wstrb=%h", grant_o, s_addr, s_wstrb);
    cyc();
    s_ready = 0; m1_valid = 0; #1;
    if (m1_ready) pulses++;
    checks++; if (pulses !== 1) begin errors++; $display("FAIL ww_pulses got %0d want 1", pulses); end
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL ww_idle got %b want 0", s_valid); end
  endtask

  task automatic test_reset_mid();
    cyc();
    m0_valid = 1; m0_addr = 32'h4000_0020; m0_wstrb = 4'h0;
    cyc(); cyc();           // two BUSY wait cycles
    resetn = 0; m0_valid = 0;
    cyc(); #1;
    checks++; if (s_valid !== 1'b0 || m0_ready !== 1'b0 || m1_ready !== 1'b0) begin
      errors++; $display("FAIL rm_after_reset got valid=%b r0=%b r1=%b want 0/0/0", s_valid, m0_ready, m1_ready);
    end
    resetn = 1;
    cyc();
    m1_valid = 1; m1_addr = 32'h4000_0030; m1_wstrb = 4'h0;
    cyc();
    s_ready = 1; s_rdata = 32'hCAFE_F00D; #1;
    checks++; if (s_valid !== 1'b1 || grant_o !== 1'b1 || s_addr !== 32'h4000_0030) begin
      errors++; $display("FAIL rm_m1_grant got valid=%b grant=%b addr=%h want 1/1/40000030", s_valid, grant_o, s_addr);
    end
    checks++; if (m1_ready !== 1'b1 || m1_rdata !== 32'hCAFE_F00D || m0_ready !== 1'b0) begin
      errors++; $display("FAIL rm_m1_resp got r1=%b d=%h r0=%b want 1/cafef00d/0", m1_ready, m1_rdata, m0_ready);
    end
    $display("txn reset_mid grant=%0d addr=%h rdata=%h", grant_o, s_addr, m1_rdata);
    cyc();
    s_ready = 0; m1_valid = 0;
  endtask

  task automatic test_idle_ready();
    cyc();
    s_ready = 1; #1;
    checks++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin errors++; $display("FAIL idle_ready got %b%b want 00", m0_ready, m1_ready); end
    cyc(); #1;
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL idle_stay got %b want 0", s_valid); end
    s_ready = 0;
  endtask

  task automatic test_timeout();
    int early;
    cyc();
    m0_valid = 1; m0_addr = 32'h4000_0040; m0_wstrb = 4'h0;
    early = 0;
    for (int i = 1; i < TO; i++) begin
      cyc(); #1;
      if (m0_ready) early++;
    end
`ifdef IOMEM_ARB_TIMEOUT_EN
    checks++; if (early !== 0) begin errors++; $display("FAIL to_early got %0d pulses want 0", early); end
    cyc(); #1;
    checks++; if (m0_ready !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL to_abort got ready=%b rdata=%h want 1/deadbeef", m0_ready, m0_rdata);
    end
    $display("txn timeout grant=%0d rdata=%h", grant_o, m0_rdata);
    cyc();
    m0_valid = 0; err_clr_i = 1; #1;
    checks++; if (err_o !== 1'b1 || s_valid !== 1'b0) begin errors++; $display("FAIL to_err_set got err=%b valid=%b want 1/0", err_o, s_valid); end
    cyc();
    err_clr_i = 0; #1;
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL to_err_clr got %b want 0", err_o); end
`else
    // Without the watchdog, BUSY waits indefinitely. Finish the transfer by hand.
    cyc(); #1;
    if (m0_ready) early++;
    checks++; if (early !== 0 || s_valid !== 1'b1 || err_o !== 1'b0) begin
      errors++; $display("FAIL no_to_wait got pulses=%0d valid=%b err=%b want 0/1/0", early, s_valid, err_o);
    end
    s_ready = 1; s_rdata = 32'h0000_0042; #1;
    checks++; if (m0_ready !== 1'b1 || m0_rdata !== 32'h0000_0042) begin
      errors++; $display("FAIL no_to_done got ready=%b rdata=%h want 1/00000042", m0_ready, m0_rdata);
    end
    $display("txn long_wait grant=%0d rdata=%h", grant_o, m0_rdata);
    cyc();
    s_ready = 0; m0_valid = 0;
`endif
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_back_to_back();
    test_wait_write();
    test_reset_mid();
    test_idle_ready();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
